// File: rtl/text_pixel_pipe.sv
// text_pixel_pipe: 80x30 text-console pixel generator with a 4-stage pipeline and a blinking underline cursor
module text_pixel_pipe #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int TEXT_AW = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         x_in,
  input  logic [9:0]         y_in,
  input  logic               active_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic [TEXT_AW-1:0] text_addr,
  input  logic [7:0]         char_data,
  output logic [11:0]        font_addr,
  input  logic [7:0]         font_data,
  input  logic               cursor_en,
  input  logic [6:0]         cursor_col,
  input  logic [4:0]         cursor_row,
  output logic               pixel_out,
  output logic               active_out,
  output logic               hsync_out,
  output logic               vsync_out
);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  typedef struct packed {
    logic [2:0] px;
    logic [3:0] gr;
    logic       rng;
    logic       act;
    logic       hs;
    logic       vs;
    logic       cur;
  } stage_t;
  localparam stage_t STAGE_RST = '{px: 3'd0, gr: 4'd0, rng: 1'b0, act: 1'b0, hs: 1'b1, vs: 1'b1, cur: 1'b0};
  logic [6:0]    col;
  logic [5:0]    row;
  logic          in_range;
  logic          frame_tick;
  logic          last_frame;
  logic          prev_vs;
  logic          blink_on;
  logic [FW-1:0] frame_cnt;
  stage_t        s0, s1, s2, s3;
  always_comb begin
    col = x_in[9:3];
    row = y_in[9:4];
    in_range = (32'(col) < COLS) && (32'(row) < ROWS);
    s0 = '{px: x_in[2:0], gr: y_in[3:0], rng: in_range, act: active_in, hs: hsync_in, vs: vsync_in,
           cur: cursor_en && col == cursor_col && row == {1'b0, cursor_row} && y_in[3:1] == 3'b111};
    frame_tick = !vsync_in && prev_vs;
    last_frame = frame_cnt == FW'(BLINK_FRAMES - 1);
    font_addr = {char_data, s2.gr};
  end
  // font_data arrives aligned with s3; ~px selects bit 7-px so the MSB is the leftmost pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      text_addr <= '0;
      s1 <= STAGE_RST;
      s2 <= STAGE_RST;
      s3 <= STAGE_RST;
      pixel_out <= 1'b0;
      active_out <= 1'b0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      prev_vs <= 1'b1;
      frame_cnt <= '0;
      blink_on <= 1'b1;
    end else begin
      text_addr <= in_range ? TEXT_AW'(32'(row) * COLS + 32'(col)) : '0;
      s1 <= s0;
      s2 <= s1;
      s3 <= s2;
      pixel_out <= s3.act && s3.rng && (font_data[~s3.px] || (s3.cur && blink_on));
      active_out <= s3.act;
      hsync_out <= s3.hs;
      vsync_out <= s3.vs;
      prev_vs <= vsync_in;
      if (frame_tick) begin
        frame_cnt <= last_frame ? '0 : frame_cnt + 1'b1;
        blink_on <= last_frame ? ~blink_on : blink_on;
      end
    end
  end
endmodule

// File: tb/tb_text_pixel_pipe.sv
// tb_text_pixel_pipe: table vectors and directed sequences checked through an output-latency scoreboard
module tb_text_pixel_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  x_in = '0, y_in = '0;
  logic        active_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [11:0] text_addr, font_addr;
  logic [7:0]  char_data, font_data;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [4:0]  cursor_row = '0;
  logic        pixel_out, active_out, hsync_out, vsync_out;

  text_pixel_pipe #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .active_in(active_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .text_addr(text_addr), .char_data(char_data),
    .font_addr(font_addr), .font_data(font_data), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .pixel_out(pixel_out),
    .active_out(active_out), .hsync_out(hsync_out), .vsync_out(vsync_out));

  always #5 clk = ~clk;

  logic [7:0] tbuf [4096];
  logic [7:0] font [4096];
  always @(posedge clk) begin
    char_data <= tbuf[text_addr];
    font_data <= font[font_addr];
  end

  typedef struct {
    logic [9:0]  x, y;
    logic        act;
    logic [11:0] ta, fa;
    logic        pix;
  } vec_t;

  typedef struct {
    int          drv;
    logic        pix, act, hs, vs;
    logic [11:0] ta, fa;
    logic        cta, cfa;
  } exp_t;

  vec_t tbl[$];
  exp_t q[$];
  int   n_vec = 0, n_bad = 0, cyc = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // text_addr is due 1 cycle after drive, font_addr 2, pixel/syncs 4
  task automatic step(logic [9:0] x, logic [9:0] y, logic a, logic hs, logic vs, logic r,
                      logic p, logic [11:0] ta, logic [11:0] fa, logic cta, logic cfa);
    exp_t e;
    foreach (q[i]) begin
      if (q[i].drv == cyc - 1 && q[i].cta) chk("text_addr", 32'(text_addr), 32'(q[i].ta));
      if (q[i].drv == cyc - 2 && q[i].cfa) chk("font_addr", 32'(font_addr), 32'(q[i].fa));
    end
    if (q.size() > 0 && q[0].drv == cyc - 4) begin
      e = q.pop_front();
      chk("pix_act_hs_vs", {28'b0, pixel_out, active_out, hsync_out, vsync_out},
          {28'b0, e.pix, e.act, e.hs, e.vs});
    end
    x_in = x; y_in = y; active_in = a; hsync_in = hs; vsync_in = vs; rst = r;
    if (r) foreach (q[i]) begin
      q[i].pix = 0; q[i].act = 0; q[i].hs = 1; q[i].vs = 1; q[i].cta = 0; q[i].cfa = 0;
    end
    if (r) e = '{drv: cyc, pix: 0, act: 0, hs: 1, vs: 1, ta: 12'd0, fa: 12'd0, cta: 1, cfa: 0};
    else e = '{drv: cyc, pix: p, act: a, hs: hs, vs: vs, ta: ta, fa: fa, cta: cta, cfa: cfa};
    q.push_back(e);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(logic vs);
    step(10'd700, 10'd0, 1'b0, 1'b1, vs, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
  endtask

  task automatic add(int x, int y, logic a, int ta, int fa, logic p);
    vec_t v;
    v = '{x: 10'(x), y: 10'(y), act: a, ta: 12'(ta), fa: 12'(fa), pix: p};
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] g0, g1;
    logic b;
    for (int i = 0; i < 4096; i++) begin tbuf[i] = 8'h20; font[i] = 8'h00; end
    tbuf[0] = 8'h41;
    tbuf[165] = 8'h5A;
    font[12'h410] = 8'b0001_1000;
    font[12'h5A7] = 8'hA5;
    g0 = 8'b0001_1000;
    g1 = 8'hA5;
    for (int i = 0; i < 8; i++) add(i, 0, 1'b1, 0, 'h410, g0[7 - i]);
    add(3, 0, 1'b0, 0, 'h410, 1'b0);
    for (int i = 0; i < 8; i++) add(40 + i, 39, 1'b1, 165, 'h5A7, g1[7 - i]);
    add(645, 0, 1'b1, 0, 'h410, 1'b0);
    add(639, 0, 1'b1, 79, 'h200, 1'b0);
    add(0, 479, 1'b1, 2320, 'h20F, 1'b0);
    add(0, 480, 1'b1, 0, 'h410, 1'b0);

    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    foreach (tbl[i])
      step(tbl[i].x, tbl[i].y, tbl[i].act, 1'b1, 1'b1, 1'b0, tbl[i].pix, tbl[i].ta, tbl[i].fa, 1'b1, 1'b1);

    // sync/active pulses of 1, 2 and 96 clocks; x out of range keeps the pixel dark
    for (int i = 0; i < 140; i++)
      step(10'd700, 10'd0, i == 2 || i inside {[6:7]} || i inside {[40:135]},
           !(i == 5 || i inside {[10:11]} || i inside {[20:115]}),
           !(i == 8 || i inside {[30:31]} || i inside {[36:131]}),
           1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    repeat (4) idle(1'b1);

    // reset mid-line: in-flight pixels are lost, the line resumes after refill
    for (int i = 0; i < 3; i++)
      step(10'(40 + i), 10'd39, 1'b1, 1'b1, 1'b1, 1'b0, g1[7 - i], 12'd165, 12'h5A7, 1'b1, 1'b1);
    step(10'd43, 10'd39, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
    for (int i = 4; i < 8; i++)
      step(10'(40 + i), 10'd39, 1'b1, 1'b1, 1'b1, 1'b0, g1[7 - i], 12'd165, 12'h5A7, 1'b1, 1'b1);
    repeat (4) idle(1'b1);

    // underline cursor at cell (3,1) over spaces, blinking every 2 frames
    cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 5'd1;
    for (int f = 0; f < 6; f++) begin
      if (f > 0) begin
        repeat (2) idle(1'b0);
        repeat (3) idle(1'b1);
      end
      b = ((f / 2) % 2) == 0;
      for (int x = 24; x < 32; x++)
        step(10'(x), 10'd29, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd83, 12'h20D, 1'b1, 1'b1);
      for (int x = 24; x < 32; x++)
        step(10'(x), 10'd30, 1'b1, 1'b1, 1'b1, 1'b0, b, 12'd83, 12'h20E, 1'b1, 1'b1);
      step(10'd24, 10'd31, 1'b1, 1'b1, 1'b1, 1'b0, b, 12'd83, 12'h20F, 1'b1, 1'b1);
      step(10'd32, 10'd30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd84, 12'h20E, 1'b1, 1'b1);
      step(10'd23, 10'd30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd82, 12'h20E, 1'b1, 1'b1);
    end

    // cursor moves one cycle after the cell was sampled
    step(10'd24, 10'd30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'd83, 12'h20E, 1'b1, 1'b1);
    cursor_col = 7'd4;
    step(10'd25, 10'd30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd83, 12'h20E, 1'b1, 1'b1);
    step(10'd32, 10'd30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'd84, 12'h20E, 1'b1, 1'b1);
    step(10'd26, 10'd30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd83, 12'h20E, 1'b1, 1'b1);
    repeat (6) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/text_pixel_pipe.md
Name: text_pixel_pipe

Overview:
- Character-cell pixel generator for the 80x30 text console.
- Maps the VGA timing generator's pixel coordinates to a text-buffer address and reads the character code back.
- Forms the 12-bit glyph address {char, glyph_row} for the synchronous font ROM, whose byte appears one cycle after the address is presented.
- Serialises the returned glyph byte into a 1-bit pixel, overlays a blinking underline cursor, and delays the syncs to stay aligned with the pixel.

Parameters:
COLS, 80, text columns per row
ROWS, 30, text rows per screen
TEXT_AW, 12, text-buffer address width (COLS*ROWS must be <= 2**TEXT_AW)
BLINK_FRAMES, 30, frames per cursor blink half-period (>=1)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
x_in  in  10  pixel column from timing generator
y_in  in  10  pixel row from timing generator
active_in  in  1  visible-region flag
hsync_in  in  1  horizontal sync, active-low
vsync_in  in  1  vertical sync, active-low
text_addr  out  TEXT_AW  text-buffer read address (registered)
char_data  in  8  text-buffer read data, valid one cycle after text_addr changes
font_addr  out  12  glyph address {char_data, glyph_row[3:0]} (combinational)
font_data  in  8  glyph row byte, valid one cycle after font_addr, MSB = leftmost pixel
cursor_en  in  1  cursor display enable
cursor_col  in  7  cursor cell column
cursor_row  in  5  cursor cell row
pixel_out  out  1  foreground pixel
active_out  out  1  delayed active_in
hsync_out  out  1  delayed hsync_in
vsync_out  out  1  delayed vsync_in

Behaviour:
- Cell decode:
  - col = x_in[9:3], row = y_in[9:4], px = x_in[2:0], glyph_row = y_in[3:0].
  - in_range = col < COLS and row < ROWS.
- Edge E1, inputs sampled:
  - text_addr <= row*COLS + col when in_range, else 0; truncated to TEXT_AW.
  - Stage 1 captures px, glyph_row, in_range, active_in, hsync_in, vsync_in.
  - Stage 1 also captures cursor_hit = cursor_en & (col==cursor_col) & (row==cursor_row) & (glyph_row>=14).
- Edge E2: text buffer returns char_data. Stage 2 copies stage 1.
- After E2: font_addr = {char_data, s2.glyph_row}, purely combinational.
- Edge E3: font ROM returns font_data. Stage 3 copies stage 2.
- Edge E4, output register:
  - pixel_out <= s3.active & s3.in_range & (font_data[7 - s3.px] | (s3.cursor_hit & blink_on)).
  - active_out, hsync_out and vsync_out take their s3 values.
- Latency: exactly 4 clocks, input sample to pixel_out/sync outputs. All 4 pipeline stages advance every clock; there is no stall.
- Blink logic:
  - frame_tick = vsync_in==0 while the registered previous vsync_in==1 (falling edge), one cycle wide.
  - frame_cnt counts frame_tick events. On reaching BLINK_FRAMES-1 with a tick, it wraps to 0 and blink_on toggles.
  - blink_on is sampled at E4; a toggle mid-frame takes effect on the next clock.
- Reset:
  - pixel_out=0, active_out=0, hsync_out=1, vsync_out=1, text_addr=0.
  - All stage valid/active bits = 0, stage syncs = 1.
  - frame_cnt=0, blink_on=1, previous-vsync register=1.
- Reset asserted mid-line:
  - Outputs take reset values on the next edge.
  - After release, the first 3 output cycles are blank (active_out=0) with syncs inactive, while the pipeline refills.
- Out-of-range cells (e.g. x>=640 with COLS=80): pixel_out=0 regardless of char/font/cursor.
- active_in=0: pixel_out=0; text_addr still updates as above.
- cursor_col/cursor_row are used as sampled at E1. A change between E1 and E4 does not affect pixels already in flight.

Test Plan:
- Buffer cell (0,0)=0x41; font ROM row 0 of 0x41 = 8'b00011000. Drive y=0, x=0..7 active → text_addr=0; font_addr=0x410 after E2; pixel_out sequence 0,0,0,1,1,0,0,0 starting exactly 4 clocks after x=0.
- x=8*5, y=16*2+7 → text_addr=2*80+5=165, font_addr={char,4'h7}; x=645 → pixel_out=0 and text_addr=0.
- Drive an hsync_in/vsync_in/active_in pattern with pulses of 1, 2 and 96 clocks → each output is an exact 4-clock-delayed copy.
- BLINK_FRAMES=2, cursor_en=1 at (3,1) over a space glyph (all zero) → rows 14–15 of cell (3,1) show pixel_out=1 for frames 0–1, 0 for frames 2–3, 1 again for frames 4–5; rows 0–13 of that cell stay 0.
- Assert rst for 1 cycle mid-visible-line → next edge pixel_out=0, hsync_out=1, vsync_out=1, blink_on=1; valid pixels resume 4 clocks after the first post-reset input.
- Change cursor_col at the cycle after E1 of cursor cell → in-flight underline still drawn at the old position; the new position is used from the next sampled pixel on.
